// File: rtl/rr_prio_arbiter16.sv
// 16-requester round-robin arbiter: rotating-start priority encode, registered
// one-hot grant with index, held until done, request drop, or hold timeout.
module rr_prio_arbiter16 #(
    parameter int N        = 16,
    parameter int IDW      = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    // Lowest set bit wins; callers pre-mask to get the rotating search order.
    function automatic logic [IDW-1:0] first_set(input logic [N-1:0] v);
        first_set = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) first_set = IDW'(i);
    endfunction

    state_t         state, state_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [HCW-1:0] hold_cnt, cnt_d;
    logic [N-1:0]   grant_d, ptr_mask, masked;
    logic [IDW-1:0] id_d, win_id;
    logic           valid_d, to_d, rel_user, rel_hold;

    always_comb begin
        for (int i = 0; i < N; i++)
            ptr_mask[i] = (IDW'(i) >= ptr);
        masked = req & ptr_mask;
        win_id = (|masked) ? first_set(masked) : first_set(req);
    end

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        cnt_d    = hold_cnt;
        grant_d  = grant;
        id_d     = grant_id;
        valid_d  = grant_valid;
        to_d     = 1'b0;
        rel_user = 1'b0;
        rel_hold = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_d = N'(1) << win_id;
                    id_d    = win_id;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rel_user = done || !req[grant_id];
                rel_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
                if (rel_user || rel_hold) begin
                    grant_d = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    ptr_d   = grant_id + IDW'(1);
                    state_d = IDLE;
                    // A release the owner also asked for is not a timeout.
                    to_d    = !rel_user;
                end else if (hold_cnt != '1) begin
                    cnt_d = hold_cnt + HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= cnt_d;
            grant       <= grant_d;
            grant_id    <= id_d;
            grant_valid <= valid_d;
            timeout     <= to_d;
        end
    end
endmodule

// File: tb/tb_rr_prio_arbiter16.sv
// Directed bench for rr_prio_arbiter16 with an 8-cycle hold limit.
module tb_rr_prio_arbiter16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        timeout;
    int checks = 0;
    int errors = 0;

    rr_prio_arbiter16 #(.N(16), .IDW(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id),
        .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 16'h0 || grant_id !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: grant=%h id=%0d valid=%b to=%b, want 0/0/0/0",
                     grant, grant_id, grant_valid, timeout);
        end
        cyc();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: valid=%b, want 0", grant_valid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 16'h0001;
        cyc();
        checks++;
        if (grant !== 16'h0001 || grant_id !== 4'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant: grant=%h id=%0d valid=%b, want 0001/0/1",
                     grant, grant_id, grant_valid);
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = '0;
        checks++;
        if (grant !== 16'h0 || grant_id !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: grant=%h id=%0d valid=%b to=%b, want 0/0/0/0",
                     grant, grant_id, grant_valid, timeout);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            cyc();
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 4'(k % 16) || grant !== (16'h1 << (k % 16))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: id=%0d grant=%h valid=%b, want id %0d",
                         k, grant_id, grant, grant_valid, k % 16);
            end
            cyc();
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 4'(k % 16)) begin
                errors++;
                $display("FAIL rr_hold[%0d]: id=%0d valid=%b, want id %0d valid 1",
                         k, grant_id, grant_valid, k % 16);
            end
            done = 1'b1;
            cyc();
            done = 1'b0;
            checks++;
            if (grant_valid !== 1'b0 || grant !== 16'h0) begin
                errors++;
                $display("FAIL rr_gap[%0d]: valid=%b grant=%h, want 0/0", k, grant_valid, grant);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 16'h0040;
        cyc();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 4'd6 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b id=%0d to=%b, want 1/6/0",
                         i, grant_valid, grant_id, timeout);
            end
            cyc();
        end
        checks++;
        if (grant_valid !== 1'b0 || grant !== 16'h0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: valid=%b grant=%h to=%b, want 0/0/1",
                     grant_valid, grant, timeout);
        end
        cyc();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd6 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: valid=%b id=%0d to=%b, want 1/6/0",
                     grant_valid, grant_id, timeout);
        end
        // done lands on the same edge the counter expires: plain release
        repeat (7) cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = '0;
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_and_timeout: valid=%b to=%b, want 0/0", grant_valid, timeout);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 16'h0006;
        cyc();
        checks++;
        if (grant_id !== 4'd1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_first: id=%0d valid=%b, want 1/1", grant_id, grant_valid);
        end
        req = 16'h0004;
        cyc();
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: valid=%b to=%b, want 0/0", grant_valid, timeout);
        end
        cyc();
        checks++;
        if (grant_id !== 4'd2 || grant !== 16'h0004 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_next: id=%0d grant=%h valid=%b, want 2/0004/1",
                     grant_id, grant, grant_valid);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h4000;
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 16'h8001;
        cyc();
        checks++;
        if (grant_id !== 4'd15 || grant !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_ptr15: id=%0d grant=%h, want 15/8000", grant_id, grant);
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        checks++;
        if (grant_id !== 4'd0 || grant !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_ptr0: id=%0d grant=%h, want 0/0001", grant_id, grant);
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        checks++;
        if (grant_id !== 4'd15 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ptr1: id=%0d valid=%b, want 15/1", grant_id, grant_valid);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0010;
        cyc();
        checks++;
        if (grant_id !== 4'd4 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_grant: id=%0d valid=%b, want 4/1", grant_id, grant_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 16'h0 || grant_id !== 4'd0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_drop: grant=%h id=%0d valid=%b, want 0/0/0",
                     grant, grant_id, grant_valid);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (grant_id !== 4'd4 || grant !== 16'h0010 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_regrant: id=%0d grant=%h valid=%b, want 4/0010/1",
                     grant_id, grant, grant_valid);
        end
        req = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_req_drop();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
